// File: rtl/alu_exec_unit.sv
// Integer ALU execute stage with an optional iterative shift-add multiplier.
// Latency: 1 cycle for single-cycle ops and illegal encodings, WIDTH+1 cycles for mul.
// Backpressure: a result is held in DONE until outReady; inReady tracks outReady in DONE for 1/cycle throughput.
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       aluOp,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branchTaken,
  output logic             illegalOp,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
    OP_SRA, OP_OR, OP_AND, OP_MUL, OP_BR, OP_ILL
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] d_res;
  logic             d_br;
  logic             d_ill;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             lt_s;
  logic             lt_u;

  // funct7-independent meaning of each funct3 in the register/immediate groups
  function automatic op_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  assign inReady  = (state == IDLE) || ((state == DONE) && outReady);
  assign accept   = inValid && inReady;
  assign busy     = (state == MUL);
  assign shamt    = operandB[SHW-1:0];
  assign lt_s     = $signed(operandA) < $signed(operandB);
  assign lt_u     = operandA < operandB;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // Decode aluOp/funct3/funct7 into a single operation selector
  always_comb begin
    op = OP_ILL;
    case (aluOp)
      2'b00: op = OP_ADD;
      2'b01: op = (funct3 == 3'b010 || funct3 == 3'b011) ? OP_ILL : OP_BR;
      2'b10: begin
        if (funct7 == 7'b0000000)
          op = base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          op = OP_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)
          op = OP_SRA;
        else if (funct7 == 7'b0000001 && funct3 == 3'b000 && ENABLE_MUL != 0)
          op = OP_MUL;
        else
          op = OP_ILL;
      end
      default: begin
        // Immediate form: funct7 only matters for shifts
        op = base_op(funct3);
        if (funct3 == 3'b101 && funct7[5])
          op = OP_SRA;
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          op = OP_ILL;
      end
    endcase
  end

  // Single-cycle datapath and branch comparison
  always_comb begin
    d_res = '0;
    d_br  = 1'b0;
    d_ill = 1'b0;
    case (op)
      OP_ADD:  d_res = operandA + operandB;
      OP_SUB:  d_res = operandA - operandB;
      OP_SLL:  d_res = operandA << shamt;
      OP_SLT:  d_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: d_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  d_res = operandA ^ operandB;
      OP_SRL:  d_res = operandA >> shamt;
      OP_SRA:  d_res = $signed(operandA) >>> shamt;
      OP_OR:   d_res = operandA | operandB;
      OP_AND:  d_res = operandA & operandB;
      OP_BR: begin
        d_res = operandA - operandB;
        case (funct3)
          3'b000:  d_br = (operandA == operandB);
          3'b001:  d_br = (operandA != operandB);
          3'b100:  d_br = lt_s;
          3'b101:  d_br = !lt_s;
          3'b110:  d_br = lt_u;
          default: d_br = !lt_u;
        endcase
      end
      OP_MUL:  d_res = '0;
      default: d_ill = 1'b1;
    endcase
  end

  // Control FSM, result registers and the shift-add multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outValid    <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      branchTaken <= 1'b0;
      illegalOp   <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) begin
            state    <= DONE;
            outValid <= 1'b1;
            result   <= acc_next;
            zero     <= (acc_next == '0);
            cnt      <= '0;
          end
        end
        default: begin
          if (accept) begin
            branchTaken <= d_br;
            illegalOp   <= d_ill;
            if (op == OP_MUL) begin
              state    <= MUL;
              outValid <= 1'b0;
              zero     <= 1'b0;
              mcand    <= operandA;
              mplier   <= operandB;
              acc      <= '0;
              cnt      <= '0;
            end else begin
              state    <= DONE;
              outValid <= 1'b1;
              result   <= d_res;
              zero     <= (d_res == '0);
            end
          end else if (state == DONE && outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
            zero     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=32) with a second no-multiply instance.
// Latency: checks 1-cycle ops, 33-cycle mul, stall hold and same-cycle re-accept.
// Backpressure: exercises outReady low while a new op is offered.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b1;
  logic [1:0]  aluOp = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;

  logic        inReady, outValid, zero, branchTaken, illegalOp, busy;
  logic [31:0] result;
  logic        nm_inReady, nm_outValid, nm_zero, nm_branchTaken, nm_illegalOp, nm_busy;
  logic [31:0] nm_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .ENABLE_MUL(1)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7),
    .operandA(operandA), .operandB(operandB),
    .outValid(outValid), .outReady(outReady), .result(result), .zero(zero),
    .branchTaken(branchTaken), .illegalOp(illegalOp), .busy(busy)
  );

  alu_exec_unit #(.WIDTH(32), .ENABLE_MUL(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(nm_inReady),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7),
    .operandA(operandA), .operandB(operandB),
    .outValid(nm_outValid), .outReady(outReady), .result(nm_result), .zero(nm_zero),
    .branchTaken(nm_branchTaken), .illegalOp(nm_illegalOp), .busy(nm_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one op while the DUT is ready; returns #1 after the accepting edge
  task automatic put(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b);
    aluOp = op; funct3 = f3; funct7 = f7; operandA = a; operandB = b;
    inValid = 1'b1;
    step();
    inValid = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eres, input logic ebr, input logic eill);
    put(op, f3, f7, a, b);
    check({tag, ".valid"}, outValid, 1);
    check({tag, ".result"}, result, eres);
    check({tag, ".zero"}, zero, eres == 32'h0);
    check({tag, ".br"}, branchTaken, ebr);
    check({tag, ".ill"}, illegalOp, eill);
    step();
  endtask

  initial begin
    int cycles;
    int bad;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.outValid", outValid, 0);
    check("rst.busy", busy, 0);
    check("rst.result", result, 0);
    check("rst.zero", zero, 0);
    check("rst.br", branchTaken, 0);
    check("rst.ill", illegalOp, 0);
    #2 rst_n = 1'b1;
    #1;
    check("rst.inReady_after", inReady, 1);
    step();

    // Single-cycle ops
    vec("sub",    2'b10, 3'b000, 7'b0100000, 32'd5,        32'd7, 32'hFFFFFFFE, 0, 0);
    vec("blt",    2'b01, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1, 0);
    vec("bltu",   2'b01, 3'b110, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 0);
    vec("beq",    2'b01, 3'b000, 7'b0000000, 32'd7,        32'd7, 32'h0,        1, 0);
    vec("bge",    2'b01, 3'b101, 7'b0000000, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 0);
    vec("bgeu",   2'b01, 3'b111, 7'b0000000, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0);
    vec("ldst",   2'b00, 3'b101, 7'b1111111, 32'd3,        32'd4, 32'd7,        0, 0);
    vec("addwrap",2'b10, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'h0,        0, 0);
    vec("sll33",  2'b10, 3'b001, 7'b0000000, 32'd1,        32'd33, 32'd2,       0, 0);
    vec("sra",    2'b10, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'hF8000000, 0, 0);
    vec("srl",    2'b10, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 32'h08000000, 0, 0);
    vec("slt",    2'b10, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1,        0, 0);
    vec("sltu",   2'b10, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0,        0, 0);
    vec("or",     2'b10, 3'b110, 7'b0000000, 32'hF0,       32'h0F, 32'hFF,      0, 0);
    vec("and",    2'b10, 3'b111, 7'b0000000, 32'hF0,       32'h3C, 32'h30,      0, 0);
    vec("srai",   2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'hF8000000, 0, 0);
    vec("addi",   2'b11, 3'b000, 7'b0100000, 32'd5,        32'd7, 32'd12,       0, 0);
    vec("slli_bad",2'b11,3'b001, 7'b0000001, 32'd1,        32'd1, 32'd0,        0, 1);
    vec("f7_bad", 2'b10, 3'b000, 7'b1111111, 32'd5,        32'd7, 32'd0,        0, 1);
    vec("br_bad", 2'b01, 3'b010, 7'b0000000, 32'd5,        32'd5, 32'd0,        0, 1);
    vec("sub_bad",2'b10, 3'b001, 7'b0100000, 32'd5,        32'd7, 32'd0,        0, 1);
    vec("mulh_bad",2'b10,3'b001, 7'b0000001, 32'd5,        32'd7, 32'd0,        0, 1);

    // Multiply, and the same encoding on the no-multiply instance
    put(2'b10, 3'b000, 7'b0000001, 32'h12345, 32'h10);
    check("nm.mul_ill", nm_illegalOp, 1);
    check("nm.mul_valid", nm_outValid, 1);
    check("nm.mul_result", nm_result, 0);
    cycles = 0;
    bad = 0;
    while (busy && cycles < 100) begin
      if (inReady || outValid) bad++;
      cycles++;
      step();
    end
    check("mul.busy_cycles", cycles, 32);
    check("mul.ready_low", bad, 0);
    check("mul.valid", outValid, 1);
    check("mul.result", result, 32'h123450);
    check("mul.ill", illegalOp, 0);
    step();

    // Stall with a pending offer, then same-cycle re-accept
    outReady = 1'b0;
    put(2'b00, 3'b000, 7'b0000000, 32'd10, 32'd20);
    check("bp.valid", outValid, 1);
    check("bp.result", result, 32'd30);
    aluOp = 2'b10; funct3 = 3'b100; funct7 = 7'b0000000;
    operandA = 32'hF0F0; operandB = 32'h0FF0;
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.hold_valid", outValid, 1);
      check("bp.hold_result", result, 32'd30);
      check("bp.hold_ready", inReady, 0);
      step();
    end
    outReady = 1'b1;
    #1;
    check("bp.ready_release", inReady, 1);
    step();
    inValid = 1'b0;
    check("bp.next_valid", outValid, 1);
    check("bp.next_result", result, 32'hFF00);
    step();
    check("bp.drain_valid", outValid, 0);
    check("bp.drain_zero", zero, 0);

    // Reset in the middle of a multiply
    put(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd4);
    repeat (9) step();
    check("mrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst.valid", outValid, 0);
    check("mrst.busy", busy, 0);
    check("mrst.result", result, 0);
    #2 rst_n = 1'b1;
    #1;
    check("mrst.inReady", inReady, 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (outValid || busy) bad++;
    end
    check("mrst.no_result", bad, 0);
    vec("post_rst", 2'b10, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have parameter ENABLE_MUL, default 1; 1 = iterative multiply supported, 0 = multiply encodings flagged illegal.
REQ-003 SHALL have one clock and one reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports:
 inValid input 1: operation offered
 inReady output 1: operation accepted when inValid&&inReady at clk edge
 aluOp input 2: 00 load/store, 01 branch, 10 R-type, 11 I-type
 funct3 input 3; funct7 input 7
 operandA input WIDTH; operandB input WIDTH
 outValid output 1: result registers hold a completed operation
 outReady input 1: consumer takes result when outValid&&outReady
 result output WIDTH: operation result
 zero output 1: result==0
 branchTaken output 1: branch condition true (aluOp 01 only, else 0)
 illegalOp output 1: encoding unsupported
 busy output 1: multiply in progress

Function
REQ-005 SHALL decode aluOp 00 as add, any funct3.
REQ-006 SHALL decode aluOp 01 by funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; result = A-B; branchTaken per comparison (signed for blt/bge); 010/011 illegal.
REQ-007 SHALL decode aluOp 10 (funct7 0000000) by funct3: 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and; funct7 0100000 with 000 sub, 101 sra; funct7 0000001 with 000 mul (low WIDTH bits of product) when ENABLE_MUL=1.
REQ-008 SHALL decode aluOp 11 as aluOp 10 ignoring funct7 and sub, except funct3 101 uses funct7[5] to select sra vs srl, and funct3 001 requires funct7==0000000.
REQ-009 SHALL treat every other combination as illegal: illegalOp=1, result=0, branchTaken=0, completing with single-cycle latency.
REQ-010 SHALL use operandB[log2(WIDTH)-1:0] as shift amount; slt/sltu yield 1 or 0 zero-extended.
REQ-011 SHALL implement states IDLE, MUL, DONE.
REQ-012 SHALL drive inReady = 1 in IDLE, = outReady in DONE, = 0 in MUL.
REQ-013 On acceptance of a non-multiply op SHALL register result/flags and enter DONE at the next edge (latency 1 cycle, outValid next cycle).
REQ-014 On acceptance of mul SHALL enter MUL, busy=1, perform one shift-add step per cycle for WIDTH cycles, then enter DONE (outValid WIDTH+1 cycles after acceptance).
REQ-015 In DONE, outputs SHALL stay stable while outReady=0; on outReady=1 with no new acceptance SHALL go to IDLE and deassert outValid.
REQ-016 In DONE with outReady=1 and inValid=1 SHALL accept the new op in that same cycle (back-to-back single-cycle throughput 1/cycle).
REQ-017 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-018 zero SHALL equal (result==0) whenever outValid=1; 0 otherwise.
REQ-019 Input changes while not accepted SHALL have no effect on any output.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, outValid=0, busy=0, result=0, zero=0, branchTaken=0, illegalOp=0, multiply counter=0.
REQ-021 Reset asserted mid-multiply SHALL abort the operation; no result is delivered after rst_n rises.
REQ-022 inReady SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-023 WIDTH=32: aluOp 10, funct7 0100000, funct3 000, A=5, B=7, outReady=1 -> next cycle outValid=1, result=0xFFFFFFFE, zero=0.
REQ-024 aluOp 01, funct3 100, A=0xFFFFFFFF, B=1 -> branchTaken=1; funct3 110 same operands -> branchTaken=0.
REQ-025 mul A=0x12345, B=0x10, outReady=1 -> busy=1 for 32 cycles, inReady=0 throughout, outValid at cycle 33, result=0x123450.
REQ-026 outReady=0 for 5 cycles after add result -> result/outValid stable, inReady=0; then outReady=1 with inValid=1 -> new op accepted same cycle, next result next cycle.
REQ-027 aluOp 10, funct7 1111111, funct3 000 -> illegalOp=1, result=0; ENABLE_MUL=0 with mul encoding -> illegalOp=1.
REQ-028 rst_n pulsed low during MUL cycle 10 -> outValid=0, busy=0 immediately; no outValid until a new op is accepted.
